// File: rtl/if_stage_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM encoding,
// the IF/ID bubble value and the PC increment.
package if_stage_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] BUBBLE_PC    = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
    localparam logic        BUBBLE_VALID = 1'b0;

endpackage

// File: rtl/if_stage_fetch_if_id_reg.sv
// IF/ID pipeline register. A bubble request beats a load; with neither
// asserted the register holds its contents.
module if_id_reg
    import if_stage_fetch_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               bubble,
    input  logic [ADDR_W-1:0]  pc_d,
    input  logic [INSTR_W-1:0] instr_d,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_pc    <= '0;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
        end else if (bubble) begin
            if_id_pc    <= ADDR_W'(BUBBLE_PC);
            if_id_instr <= INSTR_W'(BUBBLE_INSTR);
            if_id_valid <= BUBBLE_VALID;
        end else if (load) begin
            if_id_pc    <= pc_d;
            if_id_instr <= instr_d;
            if_id_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction fetch: PC, req/ack fetch FSM toward instruction memory,
// freeze and branch-redirect handling, feeding the IF/ID register.
//
// state  | meaning
// S_REQ  | request outstanding for req_addr; ack loads IF/ID (or parks data if frozen)
// S_HOLD | fetched word parked in hold_buf while frozen; no request
// S_DROP | request outstanding for a squashed address; its data will be discarded
module if_stage_fetch
    import if_stage_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid
);

    fetch_state_t       state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n;
    logic [ADDR_W-1:0]  req_addr, req_addr_n;
    logic [INSTR_W-1:0] hold_buf, hold_buf_n;
    logic [ADDR_W-1:0]  next_addr;
    logic               id_load, id_bubble;
    logic [INSTR_W-1:0] id_instr;

    assign next_addr = req_addr + ADDR_W'(PC_INC);
    assign imem_req  = !rst && (state == S_REQ || state == S_DROP);
    assign imem_addr = req_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            hold_buf <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= req_addr_n;
            hold_buf <= hold_buf_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_addr_n = req_addr;
        hold_buf_n = hold_buf;
        id_load    = 1'b0;
        id_bubble  = 1'b0;
        id_instr   = imem_rdata;

        if (branch_taken) begin
            id_bubble  = 1'b1;
            pc_n       = branch_addr;
            hold_buf_n = '0;
            // An unanswered request must keep its address on the bus, so
            // it is retired via S_DROP before the target is fetched.
            if ((state == S_REQ || state == S_DROP) && !imem_ack) begin
                state_n = S_DROP;
            end else begin
                req_addr_n = branch_addr;
                state_n    = S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        if (!freeze) begin
                            id_load    = 1'b1;
                            pc_n       = next_addr;
                            req_addr_n = next_addr;
                        end else begin
                            hold_buf_n = imem_rdata;
                            state_n    = S_HOLD;
                        end
                    end else if (!freeze) begin
                        id_bubble = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        id_load    = 1'b1;
                        id_instr   = hold_buf;
                        pc_n       = next_addr;
                        req_addr_n = next_addr;
                        state_n    = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        req_addr_n = pc;
                        state_n    = S_REQ;
                    end
                    if (!freeze) begin
                        id_bubble = 1'b1;
                    end
                end
                default: begin
                    state_n = S_REQ;
                end
            endcase
        end
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (id_load),
        .bubble      (id_bubble),
        .pc_d        (next_addr),
        .instr_d     (id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid)
    );

endmodule

// File: tb/tb_if_stage_fetch.sv
// Randomized bench for if_stage_fetch: a variable-latency memory responder
// plus a transaction-level model of the fetch stream predicting every cycle.
module tb_if_stage_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // model: where the program is, what is on the bus, and what ID should see
    logic [31:0] m_pc, m_ra, m_hword;
    logic        m_held, m_drop;
    logic [31:0] e_pc, e_instr;
    logic        e_valid;
    // memory responder
    logic        busy;
    int          cnt;

    always #5 clk = ~clk;

    if_stage_fetch #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ra = 32'h0; m_hword = 32'h0;
        m_held = 1'b0; m_drop = 1'b0;
        e_pc = 32'h0; e_instr = 32'h0; e_valid = 1'b0;
        busy = 1'b0; cnt = 0;
    endtask

    task automatic compare_outputs();
        check_val("imem_req", {31'b0, imem_req}, {31'b0, !m_held});
        check_val("imem_addr", imem_addr, m_ra);
        check_val("if_id_valid", {31'b0, if_id_valid}, {31'b0, e_valid});
        check_val("if_id_pc", if_id_pc, e_pc);
        check_val("if_id_instr", if_id_instr, e_instr);
    endtask

    // One clock of the fetch stream as seen from outside, using this cycle's inputs.
    task automatic model_update();
        if (branch_taken) begin
            e_valid = 1'b0; e_pc = 32'h0; e_instr = 32'h0;
            if (!m_held && !imem_ack) m_drop = 1'b1;
            else begin m_ra = branch_addr; m_drop = 1'b0; end
            m_pc = branch_addr;
            m_held = 1'b0;
        end else if (m_held) begin
            if (!freeze) begin
                e_valid = 1'b1; e_pc = m_ra + 32'd4; e_instr = m_hword;
                m_ra = m_ra + 32'd4; m_pc = m_ra; m_held = 1'b0;
            end
        end else if (m_drop) begin
            if (imem_ack) begin m_ra = m_pc; m_drop = 1'b0; end
            if (!freeze) begin e_valid = 1'b0; e_pc = 32'h0; e_instr = 32'h0; end
        end else if (imem_ack) begin
            if (!freeze) begin
                e_valid = 1'b1; e_pc = m_ra + 32'd4; e_instr = imem_rdata;
                m_ra = m_ra + 32'd4; m_pc = m_ra;
            end else begin
                m_hword = imem_rdata; m_held = 1'b1;
            end
        end else if (!freeze) begin
            e_valid = 1'b0; e_pc = 32'h0; e_instr = 32'h0;
        end
    endtask

    // lat_mode < 0 picks a random 0..3 wait per request
    task automatic run_cycles(input int n, input int lat_mode, input int p_fr, input int p_br);
        logic [31:0] tmp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_outputs();
            freeze       = ($urandom_range(99) < p_fr);
            branch_taken = ($urandom_range(99) < p_br);
            tmp          = $urandom;
            branch_addr  = ($urandom_range(5) == 0) ? 32'hFFFF_FFF8 : (tmp & 32'h0000_FFFC);
            if (!m_held && !busy) begin
                busy = 1'b1;
                cnt  = (lat_mode < 0) ? int'($urandom_range(3)) : lat_mode;
            end
            imem_ack   = !m_held && busy && (cnt == 0);
            imem_rdata = imem_ack ? mem_word(m_ra) : $urandom;
            @(posedge clk);
            model_update();
            if (imem_ack) busy = 1'b0;
            else if (busy) cnt--;
        end
    endtask

    task automatic reset_mid_request();
        @(negedge clk);
        freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_val("rst_req", {31'b0, imem_req}, 32'h0);
        check_val("rst_addr", imem_addr, 32'h0);
        check_val("rst_valid", {31'b0, if_id_valid}, 32'h0);
        check_val("rst_pc", if_id_pc, 32'h0);
        check_val("rst_instr", if_id_instr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("init_req", {31'b0, imem_req}, 32'h0);
        check_val("init_valid", {31'b0, if_id_valid}, 32'h0);
        rst = 1'b0;

        run_cycles(20, 0, 0, 0);      // zero-wait streaming
        run_cycles(30, 2, 0, 0);      // two wait cycles per fetch
        run_cycles(60, 0, 35, 0);     // freezes against zero-wait memory
        run_cycles(60, 3, 0, 15);     // branches during slow requests
        reset_mid_request();
        run_cycles(400, -1, 30, 12);  // everything mixed
        reset_mid_request();
        run_cycles(200, 0, 20, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
Instruction-fetch stage plus IF/ID pipeline register, sitting directly upstream of the ID stage and its register file. It keeps the PC and fetches over a req/ack handshake from an instruction memory that may have variable latency. It presents {PC+4, instruction, valid} to ID, whose Rn/Rd fields address the register-file read ports. It handles hazard freeze and branch redirect/flush coming from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC / memory address width
INSTR_W, 32, instruction width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
freeze  in  1  hazard stall from hazard unit; hold IF/ID and PC
branch_taken  in  1  EX-stage redirect pulse, one cycle
branch_addr  in  ADDR_W  redirect target
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address; stable while imem_req high and no ack
imem_ack  in  1  data valid this cycle; may be same cycle as req (zero-wait)
imem_rdata  in  INSTR_W  fetched instruction
if_id_pc  out  ADDR_W  PC+4 of the instruction in IF/ID
if_id_instr  out  INSTR_W  instruction in IF/ID
if_id_valid  out  1  IF/ID holds a real instruction; 0 = bubble

Behaviour:
- Registers: pc, req_addr, hold_buf, state, IF/ID {pc, instr, valid}.
- Reset (async): pc=RESET_PC, req_addr=RESET_PC, state=S_REQ, hold_buf=0, if_id_pc=0, if_id_instr=0, if_id_valid=0.
- imem_req = !rst & (state==S_REQ | state==S_DROP). imem_addr = req_addr.
- S_REQ: on imem_ack with freeze=0: IF/ID <= {req_addr+4, imem_rdata, 1}; pc and req_addr <= req_addr+4; stay in S_REQ. This sustains one instruction per cycle with zero-wait memory.
- S_REQ: on imem_ack with freeze=1: hold_buf <= imem_rdata; IF/ID unchanged; go to S_HOLD.
- S_REQ: no ack, freeze=0: IF/ID <= bubble {0,0,0}. No ack, freeze=1: IF/ID unchanged.
- S_HOLD: imem_req=0. While freeze=1, hold everything. When freeze=0: IF/ID <= {req_addr+4, hold_buf, 1}; pc and req_addr <= req_addr+4; go to S_REQ.
- S_DROP: a request is outstanding for a discarded address. Keep req_addr and keep imem_req=1. On ack, discard data, set req_addr <= pc, go to S_REQ. IF/ID gets a bubble each cycle unless freeze=1.
- branch_taken has the highest priority and overrides freeze:
  - IF/ID <= bubble; pc <= branch_addr; hold_buf is invalidated.
  - If state==S_REQ and no ack this cycle, the request is pending: go to S_DROP. req_addr is unchanged, so the address stays stable.
  - Otherwise (ack this cycle, S_HOLD, or S_DROP with ack): req_addr <= branch_addr; any ack data is discarded; go to S_REQ.
  - S_DROP without ack: stay in S_DROP. pc is updated to the new target, so the latest branch wins.
- PC arithmetic is modulo 2^ADDR_W; wrap from 32'hFFFF_FFFC to 0 is legal.
- Reset mid-request: req drops immediately. The memory must tolerate an abandoned request.
- freeze and branch_taken in the same cycle: the branch wins.

Decomposition:
- Shared pipeline package holds: the state encoding (S_REQ, S_HOLD, S_DROP), the bubble constant (instr 32'h0, valid 0), and the PC increment constant 4.
- Natural sub-module: if_id_reg, the IF/ID pipeline register with load / bubble / hold controls. The fetch FSM and PC stay in the top.

Test Plan:
- Zero-wait memory (ack = req), no freeze, RESET_PC=0 -> imem_addr goes 0,4,8,12 on successive cycles; if_id_pc = 4,8,12 one cycle later; valid=1 continuously.
- Memory with 2 wait cycles -> each instruction appears with valid=1 for one cycle, followed by 2 bubble cycles; imem_addr stays stable during the waits.
- freeze held for 3 cycles while an ack arrives at address 8 -> IF/ID frozen at pc=8; state S_HOLD; imem_req=0. After release: IF/ID = {12, word@8, 1}, then the fetch of 12 begins.
- branch_taken to 0x100 in the same cycle as an ack -> data discarded; IF/ID bubble; next imem_addr = 0x100; next valid instruction has if_id_pc = 0x104.
- branch_taken to 0x200 while a 3-cycle request at 0x20 is pending -> imem_addr stays 0x20 until ack; ack data dropped; then imem_addr = 0x200.
- rst asserted mid-request -> imem_req=0 and all outputs zero immediately. After deassert, the first request is at RESET_PC.
